// File: rtl/oq_pkg.sv
// Shared definitions for the output-queue FIFO egress stage.
// - FIFO word field offsets, derived from the stream width parameters.
//   FIFO word layout (msb -> lsb): {tlast, tuser, tkeep, tdata}.
// - Egress state machine encoding.
package oq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IN_PKT,
        DRAIN,
        PAUSED
    } egress_state_e;

    localparam int unsigned TDATA_LSB = 0;

    function automatic int unsigned tkeep_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned tuser_lsb(input int unsigned data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int unsigned tlast_bit(input int unsigned data_w,
                                              input int unsigned user_w);
        return data_w + data_w / 8 + user_w;
    endfunction

    function automatic int unsigned fifo_width(input int unsigned data_w,
                                               input int unsigned user_w);
        return data_w + data_w / 8 + user_w + 1;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered slice between the FIFO pop side and the AXI-Stream
// master. The main register drives the outputs; the skid register holds one
// spare word. in_ready depends only on registered state, so out_ready never
// reaches the upstream pop combinationally.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    upstream handshake; a word is taken when both are 1
//   in_data              upstream word
//   out_valid/out_ready  downstream handshake
//   out_data             main register contents
//   empty                no word held in either register
module axis_skid_buffer #(
    parameter int unsigned FIFO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FIFO_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FIFO_WIDTH-1:0] out_data,
    output logic                  empty
);

    logic                  main_valid_q, main_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [FIFO_WIDTH-1:0] main_data_q,  main_data_d;
    logic [FIFO_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic                  push, pop;

    // Only accept while the spare slot is free; the main slot either is free,
    // frees up this cycle, or the word lands in the spare slot.
    assign in_ready  = !skid_valid_q;
    assign push      = in_valid && in_ready;
    assign pop       = main_valid_q && out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign empty     = !main_valid_q && !skid_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;

        if (pop) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
        end

        // push implies the skid slot was empty, so this never collides with
        // the skid-to-main move above.
        if (push) begin
            if (!main_valid_q || pop) begin
                main_data_d  = in_data;
                main_valid_d = 1'b1;
            end else begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/oq_fifo_axis_egress.sv
// Read-domain egress stage of the output-queue FIFO. Pops fallthrough FIFO
// words into a 2-entry skid buffer that drives the AXI4-Stream master port,
// offers a packet-boundary pause handshake to the port arbiter, and counts
// accepted beats and packets.
// Ports:
//   axi_aclk, axi_resetn      clock (FIFO rd_clk), asynchronous active-low reset
//   fifo_dout/fifo_empty      fallthrough FIFO head word {tlast,tuser,tkeep,tdata}
//   fifo_rd_en                pop the FIFO head this cycle
//   m_axis_*                  AXI4-Stream master
//   pause_req/pause_ack       stop at next packet boundary / stopped and empty
//   pkt_count/word_count      wrapping counts of accepted packets / beats
module oq_fifo_axis_egress
    import oq_pkg::*;
#(
    parameter  int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter  int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter  int unsigned COUNT_WIDTH          = 32,
    localparam int unsigned FIFO_WIDTH = fifo_width(C_M_AXIS_DATA_WIDTH, C_M_AXIS_TUSER_WIDTH)
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,
    input  logic [FIFO_WIDTH-1:0]             fifo_dout,
    input  logic                              fifo_empty,
    output logic                              fifo_rd_en,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    input  logic                              pause_req,
    output logic                              pause_ack,
    output logic [COUNT_WIDTH-1:0]            pkt_count,
    output logic [COUNT_WIDTH-1:0]            word_count
);

    localparam int unsigned DW        = C_M_AXIS_DATA_WIDTH;
    localparam int unsigned KW        = C_M_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW        = C_M_AXIS_TUSER_WIDTH;
    localparam int unsigned TKEEP_LSB = tkeep_lsb(DW);
    localparam int unsigned TUSER_LSB = tuser_lsb(DW);
    localparam int unsigned TLAST_BIT = tlast_bit(DW, UW);

    egress_state_e          state_q, state_d;
    logic                   pause_ack_q, pause_ack_d;
    logic [COUNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;

    logic                  pop_permit;
    logic                  buf_in_valid;
    logic                  buf_in_ready;
    logic                  buf_empty;
    logic [FIFO_WIDTH-1:0] buf_data;
    logic                  accept;

    // Kept apart from the next-state block so fifo_rd_en can feed it without
    // forming a combinational loop through the same process.
    assign pop_permit   = ((state_q == IDLE) && !pause_req) || (state_q == IN_PKT);
    assign buf_in_valid = !fifo_empty && pop_permit;
    assign fifo_rd_en   = buf_in_valid && buf_in_ready;

    axis_skid_buffer #(
        .FIFO_WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk       (axi_aclk),
        .rst_n     (axi_resetn),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (fifo_dout),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (buf_data),
        .empty     (buf_empty)
    );

    assign m_axis_tdata = buf_data[TDATA_LSB +: DW];
    assign m_axis_tkeep = buf_data[TKEEP_LSB +: KW];
    assign m_axis_tuser = buf_data[TUSER_LSB +: UW];
    assign m_axis_tlast = buf_data[TLAST_BIT];

    assign accept     = m_axis_tvalid && m_axis_tready;
    assign pause_ack  = pause_ack_q;
    assign pkt_count  = pkt_count_q;
    assign word_count = word_count_q;

    // State follows popped words, not sink acceptance: a pause can only be
    // taken once the last word of the current packet has left the FIFO.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fifo_rd_en) begin
                    state_d = fifo_dout[TLAST_BIT] ? IDLE : IN_PKT;
                end else if (pause_req) begin
                    state_d = DRAIN;
                end
            end
            IN_PKT: begin
                if (fifo_rd_en && fifo_dout[TLAST_BIT]) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!pause_req) begin
                    state_d = IDLE;
                end else if (buf_empty) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (!pause_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pause_ack_d = (state_d == PAUSED);

        word_count_d = word_count_q;
        pkt_count_d  = pkt_count_q;
        if (accept) begin
            word_count_d = word_count_q + COUNT_WIDTH'(1);
            if (m_axis_tlast) begin
                pkt_count_d = pkt_count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q      <= IDLE;
            pause_ack_q  <= 1'b0;
            pkt_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pause_ack_q  <= pause_ack_d;
            pkt_count_q  <= pkt_count_d;
            word_count_q <= word_count_d;
        end
    end

endmodule

// File: tb/tb_oq_fifo_axis_egress.sv
// Bench for oq_fifo_axis_egress: a queue-based FIFO model feeds the DUT and
// every word pushed is expected, in order, on the stream side. Directed
// scenarios are followed by a randomized phase that also wraps word_count.
module tb_oq_fifo_axis_egress;

    localparam int unsigned DW = 32;
    localparam int unsigned UW = 8;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned CW = 8;
    localparam int unsigned FW = DW + KW + UW + 1;

    logic          clk = 1'b0;
    logic          axi_resetn;
    logic [FW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          pause_req;
    logic          pause_ack;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] word_count;

    always #5 clk = ~clk;

    oq_fifo_axis_egress #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW),
        .COUNT_WIDTH          (CW)
    ) dut (
        .axi_aclk      (clk),
        .axi_resetn    (axi_resetn),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pause_req     (pause_req),
        .pause_ack     (pause_ack),
        .pkt_count     (pkt_count),
        .word_count    (word_count)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [FW-1:0] fifo_q[$];
    logic [FW-1:0] exp_q[$];
    int unsigned   popped, accepted;
    logic [CW-1:0] exp_words, exp_pkts;
    bit            mid_pkt;
    bit            starve;

    // Last sampled DUT view
    logic          s_valid, s_rd, s_ack;
    logic [FW-1:0] s_beat;
    bit            prev_stall;
    logic [FW-1:0] prev_beat;

    function automatic logic [FW-1:0] mk(input logic last, input logic [DW-1:0] d);
        logic [UW-1:0] u;
        logic [KW-1:0] k;
        u = UW'(d ^ 32'h5A);
        k = KW'(d[3:0] | 4'b0001);
        return {last, u, k, d};
    endfunction

    task automatic push(input logic [FW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic present();
        fifo_empty = starve || (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic model_clear();
        fifo_q.delete();
        exp_q.delete();
        popped = 0; accepted = 0;
        exp_words = '0; exp_pkts = '0;
        mid_pkt = 0; prev_stall = 0;
    endtask

    // One clock cycle: called at a negedge with inputs already set.
    task automatic step();
        logic [FW-1:0] w;
        bit acc;
        present();
        #1;
        s_valid = m_axis_tvalid;
        s_rd    = fifo_rd_en;
        s_ack   = pause_ack;
        s_beat  = {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};
        check("word_count", word_count, exp_words);
        check("pkt_count", pkt_count, exp_pkts);
        if (prev_stall) begin
            check("stall_valid", s_valid, 1);
            check("stall_hold", s_beat, prev_beat);
        end
        if (s_ack) begin
            check("ack_valid", s_valid, 0);
            check("ack_rd", s_rd, 0);
            check("ack_midpkt", mid_pkt, 0);
        end
        check("lag", (popped - accepted) <= 2, 1);
        if (s_rd) check("rd_nonempty", fifo_empty, 0);
        acc        = s_valid && m_axis_tready;
        prev_stall = s_valid && !m_axis_tready;
        prev_beat  = s_beat;
        @(posedge clk);
        if (s_rd) begin
            w = fifo_q.pop_front();
            popped++;
            mid_pkt = !w[FW-1];
        end
        if (acc) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", s_beat, '0);
            end else begin
                w = exp_q.pop_front();
                check("beat", s_beat, w);
                accepted++;
                exp_words++;
                if (w[FW-1]) exp_pkts++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int unsigned budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("drain_timeout", exp_q.size(), 0);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit            seen, ended;
        int unsigned   run, p0, a0;
        logic [5:0]    pat;
        logic [FW-1:0] pending[$];
        int unsigned   len;

        axi_resetn    = 1'b0;
        m_axis_tready = 1'b0;
        pause_req     = 1'b0;
        starve        = 0;
        model_clear();
        present();
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_ack", pause_ack, 0);
        check("rst_pkts", pkt_count, 0);
        check("rst_words", word_count, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        @(negedge clk);
        @(negedge clk);
        axi_resetn = 1'b1;
        step();

        // 3-beat packet, sink always ready: pop at N, tvalid at N+1
        m_axis_tready = 1'b1;
        push(mk(0, 32'h11)); push(mk(0, 32'h22)); push(mk(1, 32'h33));
        step();
        check("t1_rd_at_n", s_rd, 1);
        check("t1_valid_at_n", s_valid, 0);
        step();
        check("t1_valid_at_n1", s_valid, 1);
        check("t1_first_data", s_beat[DW-1:0], 32'h11);
        drain(20);
        check("t1_pkts", pkt_count, 1);
        check("t1_words", word_count, 3);

        // 10 single-beat packets back-to-back: no bubbles
        for (int i = 0; i < 10; i++) push(mk(1, 32'h100 + i));
        seen = 0; ended = 0; run = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_valid && !ended) begin
                run++;
                seen = 1;
            end else if (seen) begin
                ended = 1;
            end
        end
        check("t2_run", run, 10);
        check("t2_pkts", pkt_count, 11);

        // 3-beat packet with tready 1,0,0,1,0,1
        pat = 6'b101001;
        push(mk(0, 32'h11)); push(mk(0, 32'h22)); push(mk(1, 32'h33));
        for (int i = 0; i < 6; i++) begin
            m_axis_tready = pat[i];
            step();
        end
        m_axis_tready = 1'b1;
        drain(20);
        check("t3_words", word_count, 16);
        check("t3_pkts", pkt_count, 12);

        // Pause raised during beat 2 of a 4-beat packet, second packet queued
        p0 = popped; a0 = accepted;
        for (int i = 0; i < 4; i++) push(mk(i == 3, 32'hA0 + i));
        push(mk(0, 32'hB0)); push(mk(1, 32'hB1));
        for (int i = 0; i < 10; i++) begin
            if (popped - p0 >= 2) break;
            step();
        end
        pause_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_ack) break;
        end
        check("t4_ack", s_ack, 1);
        check("t4_popped", popped - p0, 4);
        check("t4_accepted", accepted - a0, 4);
        for (int i = 0; i < 4; i++) step();
        check("t4_ack_hold", s_ack, 1);
        check("t4_no_pop", popped - p0, 4);
        pause_req = 1'b0;
        step();
        step();
        check("t4_ack_drop", s_ack, 0);
        drain(20);
        check("t4_accepted_all", accepted - a0, 6);
        check("t4_pkts", pkt_count, 14);

        // FIFO runs dry after beat 1 of a 3-beat packet for 5 cycles
        a0 = accepted;
        push(mk(0, 32'hC0));
        step();
        step();
        pause_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_gap_valid", s_valid, 0);
            check("t5_gap_noack", s_ack, 0);
        end
        push(mk(0, 32'hC1)); push(mk(1, 32'hC2));
        drain(20);
        check("t5_accepted", accepted - a0, 3);
        for (int i = 0; i < 10; i++) begin
            if (s_ack) break;
            step();
        end
        check("t5_ack_after", s_ack, 1);
        pause_req = 1'b0;
        step();
        step();

        // Asynchronous reset in the middle of a packet
        push(mk(0, 32'hD0)); push(mk(0, 32'hD1)); push(mk(1, 32'hD2));
        step();
        step();
        #2;
        axi_resetn = 1'b0;
        #1;
        check("t6_tvalid", m_axis_tvalid, 0);
        check("t6_words", word_count, 0);
        check("t6_pkts", pkt_count, 0);
        check("t6_ack", pause_ack, 0);
        model_clear();
        present();
        @(negedge clk);
        axi_resetn = 1'b1;
        push(mk(0, 32'hE0)); push(mk(1, 32'hE1));
        drain(20);
        check("t6_words_after", word_count, 2);
        check("t6_pkts_after", pkt_count, 1);

        // Randomized traffic, stalls, starvation and pause pulses
        for (int p = 0; p < 90; p++) begin
            len = $urandom_range(6, 1);
            for (int b = 0; b < len; b++) begin
                pending.push_back(mk(b == len - 1, $urandom));
            end
        end
        for (int i = 0; i < 6000; i++) begin
            if (pending.size() == 0 && exp_q.size() == 0) break;
            if (pending.size() != 0 && $urandom_range(3, 0) != 0) push(pending.pop_front());
            m_axis_tready = ($urandom_range(3, 0) != 0);
            starve        = ($urandom_range(7, 0) == 0);
            if ($urandom_range(15, 0) == 0) pause_req = ~pause_req;
            step();
        end
        pause_req     = 1'b0;
        starve        = 0;
        m_axis_tready = 1'b1;
        check("rand_pending", pending.size(), 0);
        drain(50);
        check("rand_words", word_count, exp_words);
        check("rand_pkts", pkt_count, exp_pkts);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
